// File: rtl/prover_one_minus_sched.sv
// Batch scheduler that spreads a job of nElms one-minus operations over nUnits
// shared external units, one batch of up to nUnits elements at a time.
module prover_one_minus_sched #(
    parameter int nElms   = 5,
    parameter int nUnits  = 2,
    parameter int F_NBITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [nElms*F_NBITS-1:0]    a_in,
    output logic [nUnits-1:0]           unit_en,
    output logic [nUnits*F_NBITS-1:0]   unit_a,
    input  logic [nUnits-1:0]           unit_ready,
    input  logic [nUnits*F_NBITS-1:0]   unit_c,
    output logic [nElms*F_NBITS-1:0]    c_out,
    output logic                        ready,
    output logic                        done_pulse
);

    localparam int NBATCH = (nElms + nUnits - 1) / nUnits;
    localparam int BW     = (NBATCH > 1) ? $clog2(NBATCH) : 1;
    localparam int PADW   = NBATCH * nUnits * F_NBITS;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t                     state_q, state_d;
    logic [BW-1:0]              batch_q, batch_d;
    logic                       en_dly_q;
    logic [nElms*F_NBITS-1:0]   op_q, op_d;
    logic [nElms*F_NBITS-1:0]   c_q, c_d;
    logic [PADW-1:0]            op_pad;
    logic [nUnits-1:0]          active;
    logic                       start;
    logic                       all_ready;
    logic                       last_batch;
    logic                       batch_write;

    assign start       = en & ~en_dly_q;
    // Zero padding lets the last, partial batch index past nElms safely.
    assign op_pad      = PADW'(op_q);
    assign all_ready   = &(unit_ready | ~active);
    assign last_batch  = (batch_q == BW'(NBATCH - 1));
    assign batch_write = (state_q == ST_WAIT) && all_ready;
    assign ready       = (state_q == ST_IDLE) & ~start;
    assign c_out       = c_q;

    for (genvar gi = 0; gi < nUnits; gi++) begin : g_unit
        logic [31:0] idx;
        assign idx          = 32'(batch_q) * 32'(nUnits) + 32'(gi);
        assign active[gi]   = (idx < 32'(nElms));
        assign unit_en[gi]  = (state_q == ST_ISSUE) && active[gi];
        assign unit_a[gi*F_NBITS +: F_NBITS] =
            ((state_q != ST_IDLE) && active[gi]) ? op_pad[idx*F_NBITS +: F_NBITS] : '0;
    end

    // Each element has a fixed (batch, unit) slot, so the write mux is static.
    for (genvar gi = 0; gi < nElms; gi++) begin : g_elm
        localparam int UNIT  = gi % nUnits;
        localparam int BATCH = gi / nUnits;
        assign c_d[gi*F_NBITS +: F_NBITS] =
            (batch_write && (batch_q == BW'(BATCH))) ? unit_c[UNIT*F_NBITS +: F_NBITS]
                                                     : c_q[gi*F_NBITS +: F_NBITS];
    end

    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        op_d       = op_q;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    batch_d = '0;
                    op_d    = a_in;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (all_ready) begin
                    if (last_batch) begin
                        state_d    = ST_IDLE;
                        done_pulse = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        batch_d = batch_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // en_dly resets high so an en already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            batch_q  <= '0;
            en_dly_q <= 1'b1;
            op_q     <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            batch_q  <= batch_d;
            en_dly_q <= en;
            op_q     <= op_d;
            c_q      <= c_d;
        end
    end

endmodule

// File: doc/prover_one_minus_sched.md
PROVER_ONE_MINUS_SCHED -- requirements
Module: prover_one_minus_sched

Interface
REQ-001 Parameter nElms, default 5: number of field elements per job, at least 1.
REQ-002 Parameter nUnits, default 2: number of shared external one-minus units, at least 1 and at most nElms.
REQ-003 Port clk, input, 1 bit: the single clock. Clocking is already decided as: one clock; reset is synchronous and active-high.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: job request; a job starts on the rising edge only.
REQ-006 Port a_in, input, nElms x F_NBITS: operand vector for the job.
REQ-007 Port unit_en, output, nUnits x 1: per-unit start pulse.
REQ-008 Port unit_a, output, nUnits x F_NBITS: per-unit operand.
REQ-009 Port unit_ready, input, nUnits x 1: high when the unit is idle or its result is valid; low from the cycle after unit_en until the result is valid.
REQ-010 Port unit_c, input, nUnits x F_NBITS: per-unit result, valid while unit_ready is high.
REQ-011 Port c_out, output, nElms x F_NBITS: registered results, with c_out[i] = 1 - a_in[i] mod p.
REQ-012 Port ready, output, 1 bit: block idle and no start pending.
REQ-013 Port done_pulse, output, 1 bit: one-cycle pulse at job completion.

Function
REQ-014 The block SHALL derive start = en & ~en_dly, where en_dly is en registered by one cycle.
REQ-015 The block SHALL compute nBatch = ceil(nElms/nUnits); batch b covers element indices b*nUnits+u for u < nUnits, limited to indices < nElms.
REQ-016 A unit u SHALL be active in batch b iff b*nUnits+u < nElms; inactive units SHALL see unit_en=0, and their unit_ready SHALL be ignored.
REQ-017 States SHALL be ST_IDLE, ST_ISSUE, ST_WAIT.
REQ-018 ST_IDLE SHALL go to ST_ISSUE on start, at which point the block SHALL capture a_in into an internal operand register and clear the batch counter to 0.
REQ-019 ST_ISSUE SHALL last exactly one cycle, assert unit_en for all active units, and go to ST_WAIT.
REQ-020 unit_a[u] SHALL carry operand[b*nUnits+u] throughout ST_ISSUE and ST_WAIT, and 0 otherwise.
REQ-021 In ST_WAIT, when all active unit_ready are high, the block SHALL write unit_c[u] into c_out[b*nUnits+u] for each active u in the same clock edge.
REQ-022 After that write, the block SHALL go to ST_ISSUE with b+1 if b < nBatch-1; otherwise it SHALL go to ST_IDLE and pulse done_pulse for that one transition cycle.
REQ-023 The batch counter SHALL be ceil(log2(nBatch)) bits wide, minimum 1, and SHALL never exceed nBatch-1.
REQ-024 ready SHALL equal (state==ST_IDLE) & ~start.
REQ-025 Rising edges of en while not in ST_IDLE SHALL be ignored: no queueing, and no effect on the running job.
REQ-026 a_in changes after capture SHALL NOT affect the running job.
REQ-027 c_out entries not written by the current job SHALL hold their previous values; c_out SHALL be stable while ready is high.
REQ-028 Latency: with units whose ready returns L cycles after unit_en (L >= 1), a job SHALL take nBatch*(1+L) cycles from the start cycle to done_pulse.
REQ-029 If en stays high at job end, no new job SHALL start until en falls and rises again.

Reset
REQ-030 While rst is high at a clock edge: state -> ST_IDLE, batch counter -> 0, en_dly -> 1, operand register -> 0, all c_out -> 0.
REQ-031 Outputs during and after reset: unit_en = 0, unit_a = 0, done_pulse = 0, ready = 1 until the first start.
REQ-032 Reset mid-job SHALL abort the job with no done_pulse; outstanding unit results SHALL be ignored.
REQ-033 en held high through reset release SHALL NOT start a job.

Verification
REQ-034 Defaults, a_in = {0,1,2,3,4}, unit model with L=2 -> three batches; unit_en on units {0,1}, {0,1}, {0} only; c_out = {1, 0, p-1, p-2, p-3}; done_pulse at cycle 9 after start.
REQ-035 Unit 1 ready returns 3 cycles after unit 0 in every batch -> each batch write waits for both units; results are correct; c_out is never written from a stale unit_c.
REQ-036 Second en rising edge during ST_WAIT of batch 0 -> ignored; exactly one done_pulse; ready rises only after completion.
REQ-037 rst asserted during batch 1 -> the next cycle shows ST_IDLE, all c_out = 0, ready = 1, and no done_pulse; a following clean job completes correctly.
REQ-038 nElms = nUnits = 4 -> one batch; all four unit_en pulse together; done after 1+L cycles.
REQ-039 en held high across reset release and then across job end -> no start until en toggles low then high.
